// File: rtl/wavegen_pkg.sv
// Shared definitions for the wave generator duty control path.
//
// Contents:
//   - default duty limits and reset duty (percent, 7-bit unsigned)
//   - fixed duty mode encodings (duty_mode_e)
//   - duty controller FSM state enumeration (ctrl_state_e)
//   - settings_t: one complete set of duty settings (shadow or active copy)
//   - next_mode(): fixed mode advance sequence 00->01->10->11->00
package wavegen_pkg;

    localparam int unsigned PHASE_W = 12;
    localparam int unsigned DUTY_W  = 7;
    localparam int unsigned SWEEP_W = 8;

    localparam int unsigned DUTY_MIN_DEFAULT   = 1;
    localparam int unsigned DUTY_MAX_DEFAULT   = 99;
    localparam int unsigned DUTY_RESET_DEFAULT = 50;

    typedef enum logic [1:0] {
        ModeHalf    = 2'b00,
        ModeThird   = 2'b01,
        ModeQuarter = 2'b10,
        ModeSeventh = 2'b11
    } duty_mode_e;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StPend  = 2'b01,
        StSweep = 2'b10
    } ctrl_state_e;

    typedef struct packed {
        duty_mode_e        mode;
        logic [DUTY_W-1:0] duty;
        logic              cont;
    } settings_t;

    function automatic duty_mode_e next_mode(input duty_mode_e cur);
        logic [1:0] raw;
        raw = cur + 2'b01;
        return duty_mode_e'(raw);
    endfunction

endpackage

// File: rtl/phase_wrap_detect.sv
// Phase accumulator wrap detector.
//
// A wrap is a cycle in which the incoming phase is numerically below the
// phase seen on the previous cycle. The previous-phase register resets to 0,
// so the first cycle after reset can never report a wrap.
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous, active-high reset
//   phase        in   current phase accumulator value
//   wrap         out  combinational wrap flag for the current cycle
//   period_tick  out  registered wrap flag (one cycle after the wrap cycle)
module phase_wrap_detect
    import wavegen_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [PHASE_W-1:0] phase,
    output logic               wrap,
    output logic               period_tick
);

    logic [PHASE_W-1:0] prev_phase_q;
    logic               tick_q;

    assign wrap = (phase < prev_phase_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_phase_q <= '0;
            tick_q       <= 1'b0;
        end else begin
            prev_phase_q <= phase;
            tick_q       <= wrap;
        end
    end

    assign period_tick = tick_q;

endmodule

// File: rtl/duty_controller.sv
// Duty cycle controller for the square wave generator.
//
// User requests (buttons, mode advance, continuous select) and the automatic
// triangle sweep only ever modify a shadow copy of the settings. The active
// copy, which drives the outputs, reloads from the shadow on a phase wrap, so
// a running wave period is never cut short or glitched. A request arriving
// in the wrap cycle itself lands in the shadow after the copy and therefore
// takes effect at the following wrap.
//
// Ports:
//   clk             in   system clock
//   rst             in   asynchronous, active-high reset
//   phase           in   phase accumulator value (12 bit)
//   btn_up          in   pulse: continuous duty +1 (saturating)
//   btn_down        in   pulse: continuous duty -1 (saturating)
//   mode_next       in   pulse: advance fixed duty mode
//   cont_sel        in   level: 1 = continuous duty, 0 = fixed duty
//   sweep_en        in   level: automatic triangle sweep of continuous duty
//   sweep_periods   in   wave periods per sweep step (0 behaves as 1)
//   duty_mode       out  active fixed mode (00=1/2, 01=1/3, 10=1/4, 11=1/7)
//   duty_cont       out  active continuous duty in percent
//   cont_enable     out  active continuous-mode select
//   update_pending  out  shadow settings differ from active settings
//   period_tick     out  one-cycle pulse per detected phase wrap
module duty_controller
    import wavegen_pkg::*;
#(
    parameter int unsigned DUTY_MIN   = DUTY_MIN_DEFAULT,
    parameter int unsigned DUTY_MAX   = DUTY_MAX_DEFAULT,
    parameter int unsigned DUTY_RESET = DUTY_RESET_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PHASE_W-1:0]  phase,
    input  logic                btn_up,
    input  logic                btn_down,
    input  logic                mode_next,
    input  logic                cont_sel,
    input  logic                sweep_en,
    input  logic [SWEEP_W-1:0]  sweep_periods,
    output logic [1:0]          duty_mode,
    output logic [DUTY_W-1:0]   duty_cont,
    output logic                cont_enable,
    output logic                update_pending,
    output logic                period_tick
);

    localparam logic [DUTY_W-1:0] DutyMinV   = DUTY_W'(DUTY_MIN);
    localparam logic [DUTY_W-1:0] DutyMaxV   = DUTY_W'(DUTY_MAX);
    localparam logic [DUTY_W-1:0] DutyResetV = DUTY_W'(DUTY_RESET);

    localparam settings_t SettingsReset = '{
        mode: ModeHalf,
        duty: DutyResetV,
        cont: 1'b0
    };

    // ------------------------------------------------------------------
    // Wrap detection
    // ------------------------------------------------------------------
    logic wrap;

    phase_wrap_detect u_wrap (
        .clk         (clk),
        .rst         (rst),
        .phase       (phase),
        .wrap        (wrap),
        .period_tick (period_tick)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    ctrl_state_e        state_q,    state_d;
    settings_t          shadow_q,   shadow_d;
    settings_t          active_q,   active_d;
    logic [SWEEP_W-1:0] step_cnt_q, step_cnt_d;
    logic               dir_up_q,   dir_up_d;

    logic [SWEEP_W-1:0] periods_eff;
    logic               step_due;
    logic               req_up;
    logic               req_down;

    assign periods_eff = (sweep_periods == '0) ? SWEEP_W'(1) : sweep_periods;
    // Compare with one extra bit so the +1 cannot overflow.
    assign step_due    = ({1'b0, step_cnt_q} + 9'd1) >= {1'b0, periods_eff};

    // Simultaneous up and down cancel each other.
    assign req_up   = btn_up & ~btn_down;
    assign req_down = btn_down & ~btn_up;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            shadow_q   <= SettingsReset;
            active_q   <= SettingsReset;
            step_cnt_q <= '0;
            dir_up_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            step_cnt_q <= step_cnt_d;
            dir_up_q   <= dir_up_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        active_d   = active_q;
        step_cnt_d = step_cnt_q;
        dir_up_d   = dir_up_q;

        // The active copy takes the shadow as it was before this edge.
        if (wrap) begin
            active_d = shadow_q;
        end

        case (state_q)
            StIdle, StPend: begin
                shadow_d.cont = cont_sel;
                step_cnt_d    = '0;

                // Bounds are checked before the step, so no wrap through 0/127.
                if (req_up && (shadow_q.duty < DutyMaxV)) begin
                    shadow_d.duty = shadow_q.duty + DUTY_W'(1);
                end else if (req_down && (shadow_q.duty > DutyMinV)) begin
                    shadow_d.duty = shadow_q.duty - DUTY_W'(1);
                end

                if (mode_next) begin
                    shadow_d.mode = next_mode(shadow_q.mode);
                end

                if (sweep_en) begin
                    state_d = StSweep;
                end else if (shadow_d != active_d) begin
                    state_d = StPend;
                end else begin
                    state_d = StIdle;
                end
            end

            StSweep: begin
                shadow_d.cont = 1'b1;

                if (wrap) begin
                    if (step_due) begin
                        step_cnt_d = '0;
                        // Reverse at a bound instead of stepping past it.
                        if (dir_up_q) begin
                            if (shadow_q.duty >= DutyMaxV) begin
                                dir_up_d      = 1'b0;
                                shadow_d.duty = shadow_q.duty - DUTY_W'(1);
                            end else begin
                                shadow_d.duty = shadow_q.duty + DUTY_W'(1);
                            end
                        end else begin
                            if (shadow_q.duty <= DutyMinV) begin
                                dir_up_d      = 1'b1;
                                shadow_d.duty = shadow_q.duty + DUTY_W'(1);
                            end else begin
                                shadow_d.duty = shadow_q.duty - DUTY_W'(1);
                            end
                        end
                    end else begin
                        step_cnt_d = step_cnt_q + SWEEP_W'(1);
                    end
                end

                // Shadow keeps the last sweep duty; IDLE re-evaluates pending.
                if (!sweep_en) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign duty_mode      = active_q.mode;
    assign duty_cont      = active_q.duty;
    assign cont_enable    = active_q.cont;
    assign update_pending = (shadow_q != active_q);

endmodule

// File: tb/tb_duty_controller.sv
// Self-checking bench for duty_controller: a vector table with fixed
// expectations, a cycle model feeding a scoreboard queue, and directed
// sequences for saturation, sweep and asynchronous reset.
module tb_duty_controller;

    logic        clk;
    logic        rst;
    logic [11:0] phase;
    logic        btn_up;
    logic        btn_down;
    logic        mode_next;
    logic        cont_sel;
    logic        sweep_en;
    logic [7:0]  sweep_periods;
    logic [1:0]  duty_mode;
    logic [6:0]  duty_cont;
    logic        cont_enable;
    logic        update_pending;
    logic        period_tick;

    duty_controller #(
        .DUTY_MIN   (1),
        .DUTY_MAX   (99),
        .DUTY_RESET (50)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .phase          (phase),
        .btn_up         (btn_up),
        .btn_down       (btn_down),
        .mode_next      (mode_next),
        .cont_sel       (cont_sel),
        .sweep_en       (sweep_en),
        .sweep_periods  (sweep_periods),
        .duty_mode      (duty_mode),
        .duty_cont      (duty_cont),
        .cont_enable    (cont_enable),
        .update_pending (update_pending),
        .period_tick    (period_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {mode, duty, cont, pending, tick}
    typedef struct packed {
        logic [1:0] mode;
        logic [6:0] duty;
        logic       cont;
        logic       pend;
        logic       tick;
    } outs_t;

    typedef struct {
        logic  up;
        logic  dn;
        logic  mn;
        logic  csel;
        logic  wrap;
        outs_t exp;
    } vec_t;

    int    checks = 0;
    int    errors = 0;
    outs_t exp_q[$];
    logic [11:0] ph = '0;

    // Bench reference model
    logic [11:0] m_prev;
    int          m_act_mode, m_act_duty, m_sh_mode, m_sh_duty;
    logic        m_act_cont, m_sh_cont, m_tick, m_sweep, m_dir_up;
    int          m_cnt;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic outs_t dut_outs();
        return {duty_mode, duty_cont, cont_enable, update_pending, period_tick};
    endfunction

    function automatic outs_t model_outs();
        logic pend;
        pend = (m_sh_mode != m_act_mode) || (m_sh_duty != m_act_duty) ||
               (m_sh_cont != m_act_cont);
        return {2'(m_act_mode), 7'(m_act_duty), m_act_cont, pend, m_tick};
    endfunction

    task automatic model_reset();
        m_prev     = '0;
        m_act_mode = 0;  m_sh_mode = 0;
        m_act_duty = 50; m_sh_duty = 50;
        m_act_cont = 0;  m_sh_cont = 0;
        m_tick     = 0;  m_sweep   = 0;
        m_dir_up   = 1;  m_cnt     = 0;
    endtask

    task automatic model_step(input logic up, input logic dn, input logic mn,
                              input logic [11:0] ph_new);
        logic w;
        int   pe;
        w      = ph_new < m_prev;
        m_prev = ph_new;
        m_tick = w;
        if (w) begin
            m_act_mode = m_sh_mode;
            m_act_duty = m_sh_duty;
            m_act_cont = m_sh_cont;
        end
        if (m_sweep) begin
            m_sh_cont = 1;
            if (w) begin
                pe = (sweep_periods == 0) ? 1 : int'(sweep_periods);
                m_cnt++;
                if (m_cnt >= pe) begin
                    m_cnt = 0;
                    if (m_dir_up && m_sh_duty == 99) m_dir_up = 0;
                    else if (!m_dir_up && m_sh_duty == 1) m_dir_up = 1;
                    m_sh_duty = m_dir_up ? m_sh_duty + 1 : m_sh_duty - 1;
                end
            end
        end else begin
            m_sh_cont = cont_sel;
            m_cnt     = 0;
            if (up && !dn && m_sh_duty < 99) m_sh_duty++;
            if (dn && !up && m_sh_duty > 1) m_sh_duty--;
            if (mn) m_sh_mode = (m_sh_mode + 1) % 4;
        end
        m_sweep = sweep_en;
    endtask

    // One clock: drive, push model expectation, sample 1 ns after the edge.
    task automatic drive(input logic up, input logic dn, input logic mn, input logic do_wrap);
        outs_t e;
        ph        = do_wrap ? 12'd0 : ph + 12'd1;
        phase     = ph;
        btn_up    = up;
        btn_down  = dn;
        mode_next = mn;
        model_step(up, dn, mn, ph);
        exp_q.push_back(model_outs());
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("scoreboard", 32'(dut_outs()), 32'(e));
        btn_up    = 1'b0;
        btn_down  = 1'b0;
        mode_next = 1'b0;
    endtask

    function automatic vec_t vt(input logic up, input logic dn, input logic mn,
                                input logic cs, input logic w, input logic [1:0] md,
                                input logic [6:0] du, input logic ce, input logic pd,
                                input logic tk);
        vec_t v;
        v.up = up; v.dn = dn; v.mn = mn; v.csel = cs; v.wrap = w;
        v.exp = {md, du, ce, pd, tk};
        return v;
    endfunction

    vec_t vecs[24];
    int   sw_exp[9] = '{97, 97, 98, 98, 99, 99, 98, 98, 97};
    int   sw0_exp[4] = '{97, 96, 95, 94};

    initial begin
        //          up dn mn cs w  mode duty ce pd tk
        vecs[0]  = vt(1, 0, 0, 0, 0, 0, 50, 0, 1, 0);
        vecs[1]  = vt(1, 0, 0, 0, 0, 0, 50, 0, 1, 0);
        vecs[2]  = vt(1, 0, 0, 0, 0, 0, 50, 0, 1, 0);
        vecs[3]  = vt(0, 0, 0, 0, 0, 0, 50, 0, 1, 0);
        vecs[4]  = vt(0, 0, 0, 0, 1, 0, 53, 0, 0, 1);
        vecs[5]  = vt(0, 0, 0, 0, 0, 0, 53, 0, 0, 0);
        vecs[6]  = vt(0, 0, 1, 0, 0, 0, 53, 0, 1, 0);
        vecs[7]  = vt(0, 0, 0, 0, 1, 1, 53, 0, 0, 1);
        vecs[8]  = vt(0, 0, 1, 0, 0, 1, 53, 0, 1, 0);
        vecs[9]  = vt(0, 0, 0, 0, 1, 2, 53, 0, 0, 1);
        vecs[10] = vt(0, 0, 1, 0, 0, 2, 53, 0, 1, 0);
        vecs[11] = vt(0, 0, 0, 0, 1, 3, 53, 0, 0, 1);
        vecs[12] = vt(0, 0, 1, 0, 0, 3, 53, 0, 1, 0);
        vecs[13] = vt(0, 0, 0, 0, 1, 0, 53, 0, 0, 1);
        vecs[14] = vt(0, 0, 1, 0, 0, 0, 53, 0, 1, 0);
        vecs[15] = vt(0, 0, 0, 0, 1, 1, 53, 0, 0, 1);
        vecs[16] = vt(1, 1, 0, 0, 0, 1, 53, 0, 0, 0);
        vecs[17] = vt(0, 0, 0, 0, 1, 1, 53, 0, 0, 1);
        vecs[18] = vt(1, 0, 0, 0, 0, 1, 53, 0, 1, 0);
        vecs[19] = vt(1, 0, 0, 0, 1, 1, 54, 0, 1, 1);
        vecs[20] = vt(0, 0, 0, 0, 0, 1, 54, 0, 1, 0);
        vecs[21] = vt(0, 0, 0, 0, 1, 1, 55, 0, 0, 1);
        vecs[22] = vt(0, 0, 0, 1, 0, 1, 55, 0, 1, 0);
        vecs[23] = vt(0, 0, 0, 1, 1, 1, 55, 1, 0, 1);

        rst           = 1'b1;
        phase         = '0;
        btn_up        = 1'b0;
        btn_down      = 1'b0;
        mode_next     = 1'b0;
        cont_sel      = 1'b0;
        sweep_en      = 1'b0;
        sweep_periods = 8'd2;
        model_reset();
        #1;
        check("reset_outputs", 32'(dut_outs()), 32'({2'd0, 7'd50, 1'b0, 1'b0, 1'b0}));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Table: deferred duty/mode/cont updates, cancel, wrap-coincident request
        for (int i = 0; i < 24; i++) begin
            cont_sel = vecs[i].csel;
            drive(vecs[i].up, vecs[i].dn, vecs[i].mn, vecs[i].wrap);
            check($sformatf("vec%0d", i), 32'(dut_outs()), 32'(vecs[i].exp));
        end

        // Saturation at the top
        repeat (50) drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        check("sat_max", 32'(duty_cont), 32'd99);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check("sat_max_no_pend", 32'(update_pending), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        check("sat_max_hold", 32'(duty_cont), 32'd99);

        // Saturation at the bottom
        repeat (100) drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        check("sat_min", 32'(duty_cont), 32'd1);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        check("sat_min_hold", 32'(duty_cont), 32'd1);

        // Sweep from 97 with two periods per step; buttons must be ignored
        repeat (96) drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        check("sweep_start", 32'(duty_cont), 32'd97);
        cont_sel      = 1'b0;
        sweep_periods = 8'd2;
        sweep_en      = 1'b1;
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            drive(1'b1, 1'b0, 1'b1, 1'b0);
            drive(1'b0, 1'b0, 1'b0, 1'b1);
            check($sformatf("sweep2_duty%0d", i), 32'(duty_cont), 32'(sw_exp[i]));
            check($sformatf("sweep2_cont%0d", i), 32'(cont_enable), 32'd1);
        end
        check("sweep_mode_held", 32'(duty_mode), 32'd1);

        // Zero periods behaves as one: a step on every wrap
        sweep_periods = 8'd0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            drive(1'b0, 1'b0, 1'b0, 1'b1);
            check($sformatf("sweep0_duty%0d", i), 32'(duty_cont), 32'(sw0_exp[i]));
        end

        // Leaving sweep keeps the last shadow duty
        sweep_en = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        check("sweep_exit_duty", 32'(duty_cont), 32'd93);
        check("sweep_exit_cont", 32'(cont_enable), 32'd0);

        // Asynchronous reset in the middle of a pending update
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check("pend_before_rst", 32'(update_pending), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", 32'(dut_outs()), 32'({2'd0, 7'd50, 1'b0, 1'b0, 1'b0}));
        model_reset();
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        check("post_rst_wrap", 32'(dut_outs()), 32'({2'd0, 7'd50, 1'b0, 1'b0, 1'b1}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
